scan_decoder: RTL and testbench

- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with an internal scan sequencer.
- Decodes an external select directly (manual mode), or steps its own index up, down or ping-pong at a prescaled rate.
- Drives LED walkers, 7-segment anode scanning and row/column strobes on the Basys3 designs.
- Replaces the fixed 2/3/5-bit combinational decoders wherever a registered or auto-scanned select is needed.

---
 rtl/scan_decoder.sv | 157 +++++++++++++++
 tb/tb_scan_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : scan_decoder
//  Description : Registered SEL_W-to-2^SEL_W one-hot decoder with a built-in
//                prescaled up / down / ping-pong scan sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_decoder #(
    parameter int SEL_W = 5,
    parameter int DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [SEL_W-1:0]      limit,
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      idx,
    output logic                  step,
    output logic                  wrap
);

    localparam int c_OUT_W = 2**SEL_W;
    localparam int c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DIV - 1);

    localparam logic [1:0] c_MODE_MAN    = 2'b00;
    localparam logic [1:0] c_MODE_UP     = 2'b01;
    localparam logic [1:0] c_MODE_DOWN   = 2'b10;
    localparam logic [1:0] c_MODE_BOUNCE = 2'b11;

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [SEL_W-1:0]   r_idx;
    logic [c_OUT_W-1:0] r_out;
    logic               r_step;
    logic               r_wrap;
    logic [c_CNT_W-1:0] r_cnt;
    dir_t               r_dir;
    logic [1:0]         r_mode_q;

    logic [SEL_W-1:0]   w_idx_nxt;
    logic [c_OUT_W-1:0] w_out_nxt;
    logic               w_step_nxt;
    logic               w_wrap_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    dir_t               w_dir_nxt;
    logic               w_mode_chg;
    logic               w_tick;
    logic [SEL_W-1:0]   w_idx_clamp;

    assign w_mode_chg  = (mode != r_mode_q);
    assign w_tick      = (r_cnt == c_CNT_MAX);
    assign w_idx_clamp = (r_idx < limit) ? r_idx : limit;

    always_comb begin
        w_idx_nxt  = r_idx;
        w_cnt_nxt  = r_cnt;
        w_dir_nxt  = r_dir;
        w_step_nxt = 1'b0;
        w_wrap_nxt = 1'b0;

        if (!en) begin
            w_cnt_nxt = '0;
        end else if (w_mode_chg) begin
            // A mode switch restarts the prescaler and never steps on that edge
            w_cnt_nxt = '0;
            case (mode)
                c_MODE_MAN:  w_idx_nxt = sel;
                c_MODE_DOWN: w_dir_nxt = DIR_DOWN;
                default:     w_dir_nxt = DIR_UP;
            endcase
        end else if (mode == c_MODE_MAN) begin
            w_idx_nxt = sel;
            w_cnt_nxt = '0;
        end else if (!w_tick) begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end else begin
            w_cnt_nxt  = '0;
            w_step_nxt = 1'b1;
            case (mode)
                c_MODE_UP: begin
                    if (r_idx < limit) begin
                        w_idx_nxt = r_idx + SEL_W'(1);
                    end else begin
                        w_idx_nxt  = '0;
                        w_wrap_nxt = 1'b1;
                    end
                end
                c_MODE_DOWN: begin
                    if (r_idx == '0 || r_idx > limit) begin
                        w_idx_nxt  = limit;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx - SEL_W'(1);
                    end
                end
                c_MODE_BOUNCE: begin
                    if (r_dir == DIR_UP) begin
                        if (r_idx < limit) begin
                            w_idx_nxt = r_idx + SEL_W'(1);
                        end else begin
                            // Reverse without revisiting the end index
                            w_dir_nxt  = DIR_DOWN;
                            w_wrap_nxt = 1'b1;
                            w_idx_nxt  = (limit == '0) ? '0 : w_idx_clamp - SEL_W'(1);
                        end
                    end else begin
                        if (r_idx != '0) begin
                            w_idx_nxt = (r_idx > limit) ? limit : r_idx - SEL_W'(1);
                        end else begin
                            w_dir_nxt  = DIR_UP;
                            w_wrap_nxt = 1'b1;
                            w_idx_nxt  = (limit == '0) ? '0 : SEL_W'(1);
                        end
                    end
                end
                default: begin
                    w_idx_nxt = r_idx;
                end
            endcase
        end

        w_out_nxt = en ? (c_OUT_W'(1) << w_idx_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_out    <= '0;
            r_step   <= 1'b0;
            r_wrap   <= 1'b0;
            r_cnt    <= '0;
            r_dir    <= DIR_UP;
            r_mode_q <= c_MODE_MAN;
        end else begin
            r_idx    <= w_idx_nxt;
            r_out    <= w_out_nxt;
            r_step   <= w_step_nxt;
            r_wrap   <= w_wrap_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dir    <= w_dir_nxt;
            r_mode_q <= mode;
        end
    end

    assign out  = r_out;
    assign idx  = r_idx;
    assign step = r_step;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_decoder
//  Description : Randomised and directed bench for scan_decoder, two parameter
//                sets, compared against a behavioural model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [4:0]  sel;
    logic [4:0]  limit;

    logic [31:0] out_a;
    logic [4:0]  idx_a;
    logic        step_a, wrap_a;
    logic [7:0]  out_b;
    logic [2:0]  idx_b;
    logic        step_b, wrap_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(5), .DIV(4)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .limit(limit),
        .out(out_a), .idx(idx_a), .step(step_a), .wrap(wrap_a)
    );

    scan_decoder #(.SEL_W(3), .DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[2:0]), .limit(limit[2:0]),
        .out(out_b), .idx(idx_b), .step(step_b), .wrap(wrap_b)
    );

    // Behavioural model state: position, prescaler phase, direction (0 up, 1 down)
    typedef struct {
        int idx;
        int cnt;
        int dir;
        int mq;
        int step;
        int wrap;
        int en_q;
    } ms_t;

    ms_t ma, mb;

    function automatic ms_t model(input ms_t s, input bit r, input bit e, input int m,
                                  input int sl, input int lm, input int w, input int div);
        ms_t n;
        int  mask;
        mask = (1 << w) - 1;
        sl   = sl & mask;
        lm   = lm & mask;
        n    = s;
        n.step = 0;
        n.wrap = 0;
        if (r) begin
            n = '{0, 0, 0, 0, 0, 0, 0};
            return n;
        end
        n.mq   = m;
        n.en_q = e;
        if (!e) begin
            n.cnt = 0;
            return n;
        end
        if (m != s.mq) begin
            n.cnt = 0;
            if (m == 0) n.idx = sl;
            else        n.dir = (m == 2) ? 1 : 0;
        end else if (m == 0) begin
            n.idx = sl;
            n.cnt = 0;
        end else if (s.cnt < div - 1) begin
            n.cnt = s.cnt + 1;
        end else begin
            n.cnt  = 0;
            n.step = 1;
            if (m == 1) begin
                if (s.idx < lm) n.idx = s.idx + 1;
                else begin n.idx = 0; n.wrap = 1; end
            end else if (m == 2) begin
                if (s.idx == 0 || s.idx > lm) begin n.idx = lm; n.wrap = 1; end
                else n.idx = s.idx - 1;
            end else if (s.dir == 0) begin
                if (s.idx < lm) n.idx = s.idx + 1;
                else begin
                    n.dir  = 1;
                    n.wrap = 1;
                    n.idx  = (lm == 0) ? 0 : ((s.idx < lm) ? s.idx : lm) - 1;
                end
            end else begin
                if (s.idx > lm)      n.idx = lm;
                else if (s.idx > 0)  n.idx = s.idx - 1;
                else begin
                    n.dir  = 0;
                    n.wrap = 1;
                    n.idx  = (lm == 0) ? 0 : 1;
                end
            end
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] onehot(input ms_t s);
        logic [31:0] v;
        v = 32'h0;
        if (s.en_q != 0) v[s.idx] = 1'b1;
        return v;
    endfunction

    task automatic cycle(input bit r, input bit e, input logic [1:0] m,
                         input logic [4:0] s, input logic [4:0] l);
        rst   = r;
        en    = e;
        mode  = m;
        sel   = s;
        limit = l;
        @(posedge clk);
        ma = model(ma, r, e, int'(m), int'(s), int'(l), 5, 4);
        mb = model(mb, r, e, int'(m), int'(s), int'(l), 3, 1);
        #1;
        check("a_idx",  32'(idx_a),  32'(ma.idx));
        check("a_out",  out_a,       onehot(ma));
        check("a_step", 32'(step_a), 32'(ma.step));
        check("a_wrap", 32'(wrap_a), 32'(ma.wrap));
        check("b_idx",  32'(idx_b),  32'(mb.idx));
        check("b_out",  32'(out_b),  onehot(mb));
        check("b_step", 32'(step_b), 32'(mb.step));
        check("b_wrap", 32'(wrap_b), 32'(mb.wrap));
    endtask

    initial begin
        logic [1:0] r_m;
        logic [4:0] r_l;
        bit         r_e;
        ma = '{0, 0, 0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0, 0, 0};

        // Reset with enable and scan requested
        cycle(1, 1, 2'b01, 5'd0, 5'd5);
        cycle(1, 1, 2'b01, 5'd0, 5'd5);
        check("rst_out_zero", out_a, 32'h0);
        check("rst_idx_zero", 32'(idx_a), 32'h0);
        // Disabled manual select keeps output dark
        for (int i = 0; i < 3; i++) cycle(0, 0, 2'b00, 5'd7, 5'd0);
        check("dis_out_zero", out_a, 32'h0);

        // Manual sweep
        for (int i = 0; i < 32; i++) cycle(0, 1, 2'b00, 5'(i), 5'(31 - i));
        check("man_last_out", out_a, 32'h8000_0000);

        // Scan up, limit 5, from idx 0
        cycle(0, 1, 2'b00, 5'd0, 5'd5);
        for (int i = 0; i < 26; i++) begin
            cycle(0, 1, 2'b01, 5'd0, 5'd5);
            if (ma.idx == 5) check("up_out_at5", out_a, 32'h0000_0020);
        end

        // Scan down with limit 31, shrink to 3 mid-scan
        cycle(0, 1, 2'b00, 5'd0, 5'd31);
        for (int i = 0; i < 50; i++) cycle(0, 1, 2'b10, 5'd0, (ma.idx <= 20 && i > 4) ? 5'd3 : 5'd31);
        for (int i = 0; i < 20; i++) cycle(0, 1, 2'b10, 5'd0, 5'd3);

        // Bounce, limit 3 then 0
        cycle(0, 1, 2'b00, 5'd0, 5'd3);
        for (int i = 0; i < 30; i++) cycle(0, 1, 2'b11, 5'd0, 5'd3);
        for (int i = 0; i < 10; i++) cycle(0, 1, 2'b11, 5'd0, 5'd0);

        // Disable mid-scan, then reset mid-bounce
        for (int i = 0; i < 6; i++) cycle(0, 1, 2'b11, 5'd0, 5'd7);
        for (int i = 0; i < 3; i++) cycle(0, 0, 2'b11, 5'd0, 5'd7);
        check("en0_out_zero", out_a, 32'h0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 2'b11, 5'd0, 5'd7);
        cycle(1, 1, 2'b11, 5'd0, 5'd7);
        check("midrst_idx", 32'(idx_a), 32'h0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 2'b11, 5'd0, 5'd7);

        // Randomised traffic with sticky mode/limit/enable
        r_m = 2'b01;
        r_l = 5'd9;
        r_e = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) r_m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0)
                r_l = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            if ($urandom_range(0, 24) == 0) r_e = ~r_e;
            cycle(($urandom_range(0, 299) == 0), r_e, r_m, 5'($urandom), r_l);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
